// File: rtl/instr_sequencer.sv
// Major-state sequencer for the PDP-8 core: walks each instruction through
// FETCH/LOAD/DECODE, optional DEFER and EXEC, with run/step/halt and bus timeout.
module instr_sequencer #(
    parameter int unsigned TMO_CYCLES = 15
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        run,
    input  logic        step,
    input  logic        irqReq,
    input  logic        ionEnable,
    input  logic [11:0] ir,
    input  logic        memAck,
    output logic        memReq,
    output logic        memWrite,
    output logic        ckFetch,
    output logic        irqOverride,
    output logic        irqAck,
    output logic        pcInc,
    output logic        isFetch,
    output logic        isDefer,
    output logic        isExec,
    output logic        halted,
    output logic        busErr
);

    typedef enum logic [2:0] {
        S_HALT, S_FETCH, S_LOAD, S_DECODE, S_DEFER, S_EXEC
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYCLES - 1);

    state_t     state_q, state_d;
    logic       stepping_q, stepping_d;
    logic       irq_take_q, irq_take_d;
    logic       isz_wr_q, isz_wr_d;
    logic       gap_q, gap_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       bus_err_q, bus_err_d;

    logic [2:0] op;
    logic       ind;
    logic       mem_state;
    logic       mem_req;
    logic       ack;
    logic       timeout;
    logic       boundary;

    assign op  = ir[11:9];
    assign ind = ir[8];

    // A request is suppressed for the one cycle after any acknowledged cycle;
    // this also provides the idle cycle between the ISZ read and write.
    assign mem_state = (state_q == S_FETCH) || (state_q == S_DEFER) || (state_q == S_EXEC);
    assign mem_req   = mem_state && !gap_q;
    assign ack       = mem_req && memAck;
    assign timeout   = mem_req && !memAck && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d    = state_q;
        stepping_d = stepping_q;
        irq_take_d = irq_take_q;
        isz_wr_d   = isz_wr_q;
        gap_d      = ack;
        tmo_cnt_d  = (mem_req && !memAck) ? tmo_cnt_q + 8'd1 : 8'd0;
        bus_err_d  = bus_err_q;
        boundary   = 1'b0;

        case (state_q)
            S_HALT: begin
                if (!bus_err_q && (run || step)) begin
                    state_d    = S_FETCH;
                    stepping_d = step;
                end
            end
            S_FETCH:  if (ack) state_d = S_LOAD;
            S_LOAD:   state_d = S_DECODE;
            S_DECODE: begin
                if (op <= 3'd5 && ind) begin
                    state_d = S_DEFER;
                end else if (op <= 3'd4) begin
                    state_d  = S_EXEC;
                    isz_wr_d = 1'b0;
                end else begin
                    boundary = 1'b1;
                end
            end
            S_DEFER: begin
                if (ack) begin
                    if (op == 3'd5) begin
                        boundary = 1'b1;
                    end else begin
                        state_d  = S_EXEC;
                        isz_wr_d = 1'b0;
                    end
                end
            end
            S_EXEC: begin
                if (ack) begin
                    if (op == 3'd2 && !isz_wr_q) isz_wr_d = 1'b1;
                    else                         boundary = 1'b1;
                end
            end
            default: state_d = S_HALT;
        endcase

        if (boundary) begin
            state_d    = (run && !stepping_q) ? S_FETCH : S_HALT;
            stepping_d = 1'b0;
        end

        if (timeout) begin
            state_d    = S_HALT;
            bus_err_d  = 1'b1;
            tmo_cnt_d  = 8'd0;
            stepping_d = 1'b0;
        end

        // Interrupts are sampled only on the cycle FETCH is entered.
        if (state_d == S_FETCH && state_q != S_FETCH)
            irq_take_d = irqReq && ionEnable;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_HALT;
            stepping_q <= 1'b0;
            irq_take_q <= 1'b0;
            isz_wr_q   <= 1'b0;
            gap_q      <= 1'b0;
            tmo_cnt_q  <= 8'd0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stepping_q <= stepping_d;
            irq_take_q <= irq_take_d;
            isz_wr_q   <= isz_wr_d;
            gap_q      <= gap_d;
            tmo_cnt_q  <= tmo_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign memReq      = mem_req;
    assign memWrite    = mem_req && (state_q == S_EXEC) &&
                         (op == 3'd3 || op == 3'd4 || (op == 3'd2 && isz_wr_q));
    assign ckFetch     = (state_q == S_LOAD);
    assign irqOverride = irq_take_q && ((state_q == S_FETCH) || (state_q == S_LOAD));
    assign irqAck      = (state_q == S_LOAD) && irq_take_q;
    assign pcInc       = (state_q == S_LOAD) && !irq_take_q;
    assign isFetch     = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_DECODE);
    assign isDefer     = (state_q == S_DEFER);
    assign isExec      = (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);
    assign busErr      = bus_err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a responder acks each request on its
// third cycle and an IR model loads memory data (or 4000) on ckFetch.
module tb_instr_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        run = 1'b0, step = 1'b0, irqReq = 1'b0, ionEnable = 1'b0;
    logic [11:0] ir = 12'o0;
    logic        memAck = 1'b0;
    logic        memReq, memWrite, ckFetch, irqOverride, irqAck, pcInc;
    logic        isFetch, isDefer, isExec, halted, busErr;

    logic [11:0] mem_data = 12'o0;
    logic        ack_en = 1'b1;
    int          age = 0;
    logic        prev_ack = 1'b0;

    localparam int FE = 0, DF = 1, EX = 2, CK = 3, PC = 4, IA = 5, OV = 6,
                   RQ = 7, WR = 8, AK = 9, XA = 10, BB = 11, NC = 12;
    int cnt [NC];
    int base[NC];

    int n_chk = 0, n_pass = 0;

    instr_sequencer #(.TMO_CYCLES(15)) dut (
        .CLK(CLK), .RESET(RESET), .run(run), .step(step), .irqReq(irqReq),
        .ionEnable(ionEnable), .ir(ir), .memAck(memAck), .memReq(memReq),
        .memWrite(memWrite), .ckFetch(ckFetch), .irqOverride(irqOverride),
        .irqAck(irqAck), .pcInc(pcInc), .isFetch(isFetch), .isDefer(isDefer),
        .isExec(isExec), .halted(halted), .busErr(busErr)
    );

    always #5 CLK = ~CLK;

    initial for (int i = 0; i < NC; i++) cnt[i] = 0;

    // Memory responder, IR model and per-cycle event counters, all on the falling edge.
    always @(negedge CLK) begin
        memAck = ack_en && memReq && (age >= 2);
        age    = (memReq && !memAck) ? age + 1 : 0;
        if (prev_ack && memReq) cnt[BB]++;
        prev_ack = memReq && memAck;
        if (ckFetch) ir = irqOverride ? 12'o4000 : mem_data;
        if (isFetch)                    cnt[FE]++;
        if (isDefer)                    cnt[DF]++;
        if (isExec)                     cnt[EX]++;
        if (ckFetch)                    cnt[CK]++;
        if (pcInc)                      cnt[PC]++;
        if (irqAck)                     cnt[IA]++;
        if (irqOverride)                cnt[OV]++;
        if (memReq)                     cnt[RQ]++;
        if (memReq && memWrite)         cnt[WR]++;
        if (memReq && memAck)           cnt[AK]++;
        if (isExec && memReq && memAck) cnt[XA]++;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    task automatic snap();
        for (int i = 0; i < NC; i++) base[i] = cnt[i];
    endtask

    function automatic int d(input int idx);
        return cnt[idx] - base[idx];
    endfunction

    task automatic do_reset();
        RESET = 1'b1;
        cyc();
        cyc();
        RESET = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        bit busy = 1'b0;
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            cyc();
            if (!halted) busy = 1'b1;
            else if (busy) done = 1'b1;
        end
        chk({tag, "_reached_halt"}, int'(done), 1);
    endtask

    task automatic run_one(input string tag, input logic [11:0] data);
        mem_data = data;
        snap();
        run = 1'b1;
        cyc();
        run = 1'b0;
        wait_halt(tag);
    endtask

    task automatic expect_instr(input string tag, input int fe, input int df, input int ex,
                                input int pc, input int ia, input int ov, input int wr,
                                input int ak);
        chk({tag, "_fetch_cycles"}, d(FE), fe);
        chk({tag, "_defer_cycles"}, d(DF), df);
        chk({tag, "_exec_cycles"},  d(EX), ex);
        chk({tag, "_ckfetch"},      d(CK), 1);
        chk({tag, "_pcinc"},        d(PC), pc);
        chk({tag, "_irqack"},       d(IA), ia);
        chk({tag, "_override"},     d(OV), ov);
        chk({tag, "_write_cycles"}, d(WR), wr);
        chk({tag, "_acks"},         d(AK), ak);
        chk({tag, "_gap"},          d(BB), 0);
    endtask

    initial begin
        do_reset();
        chk("rst_halted",  int'(halted),  1);
        chk("rst_memreq",  int'(memReq),  0);
        chk("rst_buserr",  int'(busErr),  0);
        chk("rst_ckfetch", int'(ckFetch), 0);
        chk("rst_isfetch", int'(isFetch), 0);
        chk("rst_isexec",  int'(isExec),  0);

        run_one("tad", 12'o1234);
        expect_instr("tad", 5, 0, 3, 1, 0, 0, 0, 2);

        run_one("jmpi", 12'o5600);
        expect_instr("jmpi", 5, 3, 0, 1, 0, 0, 0, 2);

        run_one("isz", 12'o2100);
        expect_instr("isz", 5, 0, 7, 1, 0, 0, 3, 3);
        chk("isz_exec_acks", d(XA), 2);

        irqReq = 1'b1; ionEnable = 1'b1;
        run_one("irq", 12'o1234);
        expect_instr("irq", 5, 0, 3, 0, 1, 4, 3, 2);

        ionEnable = 1'b0;
        run_one("irq_off", 12'o1234);
        expect_instr("irq_off", 5, 0, 3, 1, 0, 0, 0, 2);

        // Request rising after FETCH entry must wait for the next fetch.
        irqReq = 1'b0; ionEnable = 1'b1;
        mem_data = 12'o1234;
        snap();
        run = 1'b1;
        cyc();
        run = 1'b0; irqReq = 1'b1;
        wait_halt("irq_late");
        expect_instr("irq_late", 5, 0, 3, 1, 0, 0, 0, 2);
        irqReq = 1'b0; ionEnable = 1'b0;

        mem_data = 12'o7000;
        snap();
        step = 1'b1;
        cyc();
        step = 1'b0;
        wait_halt("step");
        expect_instr("step", 5, 0, 0, 1, 0, 0, 0, 1);

        // Step while run is held still halts after one instruction.
        snap();
        run = 1'b1; step = 1'b1;
        cyc();
        step = 1'b0;
        wait_halt("step_run");
        chk("step_run_ckfetch", d(CK), 1);
        run = 1'b0;
        cyc();

        // Free run: second fetch follows the first instruction, with the ack gap.
        mem_data = 12'o1234;
        snap();
        run = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        chk("freerun_ckfetch", d(CK), 2);
        chk("freerun_gap", d(BB), 0);
        run = 1'b0;
        wait_halt("freerun");

        // run dropped during the ISZ read: write still completes.
        mem_data = 12'o2100;
        snap();
        run = 1'b1;
        for (int i = 0; i < 20 && !isExec; i++) cyc();
        chk("iszdrop_in_exec", int'(isExec), 1);
        run = 1'b0;
        wait_halt("iszdrop");
        chk("iszdrop_ckfetch", d(CK), 1);
        chk("iszdrop_exec",    d(EX), 7);
        chk("iszdrop_writes",  d(WR), 3);

        // Reset in the middle of a fetch request.
        run = 1'b1;
        cyc();
        cyc();
        chk("midrst_req_before", int'(memReq), 1);
        RESET = 1'b1;
        run = 1'b0;
        cyc();
        chk("midrst_req_after", int'(memReq), 0);
        chk("midrst_halted",    int'(halted), 1);
        RESET = 1'b0;
        cyc();

        // Bus timeout.
        ack_en = 1'b0;
        run_one("tmo", 12'o1234);
        chk("tmo_req_cycles", d(RQ), 15);
        chk("tmo_buserr",     int'(busErr), 1);
        chk("tmo_memreq",     int'(memReq), 0);
        chk("tmo_ckfetch",    d(CK), 0);
        snap();
        step = 1'b1;
        cyc();
        step = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        chk("tmo_step_halted", int'(halted), 1);
        chk("tmo_step_req",    d(RQ), 0);
        chk("tmo_still_err",   int'(busErr), 1);
        ack_en = 1'b1;
        do_reset();
        chk("tmo_rst_buserr", int'(busErr), 0);
        chk("tmo_rst_halted", int'(halted), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
